// File: rtl/aes_key_expand.sv
// Purpose : AES-128 key schedule, computes and stores round keys 0..10 for the inverse datapath.
// Latency : key accepted at edge N, round key r stored at edge N+r, keys_done from edge N+10; rd_key 1 cycle after rd_round.
// Backpressure: key_ready is low during expansion (and in reset); key_valid is ignored then.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   aes_key    - 128-bit cipher key, bit 127 = MSB of first key byte
//   key_valid  - aes_key valid this cycle
//   key_ready  - block accepts a key this cycle (IDLE or DONE, not in reset)
//   busy       - expansion in progress
//   keys_done  - all 11 round keys stored and stable
//   rd_round   - round-key read index (11..15 read as zero)
//   rd_key     - registered round key selected by rd_round
//
// Build option: define AES_KEY_REVERSE_EN to read round keys in decryption
// order (rd_round 0 returns round key 10).

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] aes_key,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_done,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    state_t         state;
    logic [3:0]     round_cnt;
    logic [7:0]     rcon;
    logic [127:0]   cur_key;      // last round key produced, feeds the next round
    logic [127:0]   key_mem [0:10];

    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    tmp_word;
    logic [31:0]    nw0, nw1, nw2, nw3;
    logic [127:0]   next_key;
    logic [7:0]     rcon_next;
    logic [3:0]     rd_idx;

    // key_ready has to drop in the same cycle rst rises, so it cannot be a flop.
    assign key_ready = !rst && (state != EXPAND);

    // One round of the schedule: RotWord, SubWord, rcon, then chained XOR.
    assign rot_word = {cur_key[23:0], cur_key[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
        end
    endgenerate

    assign tmp_word = sub_word ^ {rcon, 24'h0};
    assign nw0      = cur_key[127:96] ^ tmp_word;
    assign nw1      = cur_key[95:64]  ^ nw0;
    assign nw2      = cur_key[63:32]  ^ nw1;
    assign nw3      = cur_key[31:0]   ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    // xtime in GF(2^8): 01,02,..,80,1B,36
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= 4'd0;
            rcon      <= 8'h00;
            cur_key   <= '0;
            busy      <= 1'b0;
            keys_done <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                key_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        key_mem[0] <= aes_key;
                        cur_key    <= aes_key;
                        round_cnt  <= 4'd1;
                        rcon       <= 8'h01;
                        keys_done  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_mem[round_cnt] <= next_key;
                    cur_key            <= next_key;
                    rcon               <= rcon_next;
                    if (round_cnt == 4'd10) begin
                        // counter parks at 10, never wraps
                        busy      <= 1'b0;
                        keys_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_KEY_REVERSE_EN
    // Decryption order: index 0 returns the last round key.
    assign rd_idx = 4'd10 - rd_round;
`else
    assign rd_idx = rd_round;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key <= '0;
        end else if (rd_round > 4'd10) begin
            rd_key <= '0;
        end else begin
            rd_key <= key_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Purpose : self-checking bench for aes_key_expand against a word-level FIPS-197 key schedule model.
// Latency : checks acceptance at edge N, busy through N+9, keys_done from N+10, 1-cycle reads.
// Backpressure: checks key_ready low during expansion and reset, and that key_valid is ignored there.

module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] aes_key;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_done;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_keys [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .aes_key   (aes_key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .keys_done (keys_done),
        .rd_round  (rd_round),
        .rd_key    (rd_key)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // rd_round value that addresses physical round key p
    function automatic logic [3:0] rd_for(input int p);
`ifdef AES_KEY_REVERSE_EN
        return 4'(10 - p);
`else
        return 4'(p);
`endif
    endfunction

    function automatic logic [127:0] exp_read(input int r);
        if (r > 10) return '0;
`ifdef AES_KEY_REVERSE_EN
        return exp_keys[10 - r];
`else
        return exp_keys[r];
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept key at edge N, run to N+10 checking handshake each cycle.
    task automatic run_expand(input logic [127:0] key, input logic [127:0] ignored_key,
                              input bit inject, input bit midread, input string tag);
        aes_key   = key;
        key_valid = 1'b1;
        step();                                   // edge N
        key_valid = 1'b0;
        check({tag, " busy@N"},      busy,      1'b1);
        check({tag, " ready@N"},     key_ready, 1'b0);
        check({tag, " done@N"},      keys_done, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            if (inject && c == 3) begin
                aes_key   = ignored_key;
                key_valid = 1'b1;
            end
            if (midread && c == 1) rd_round = rd_for(5);
            step();                               // edge N+c
            key_valid = 1'b0;
            aes_key   = key;
            if (midread && c == 1) check({tag, " midread r5"}, rd_key, '0);
            check($sformatf("%s busy@N+%0d", tag, c),  busy,      1'b1);
            check($sformatf("%s ready@N+%0d", tag, c), key_ready, 1'b0);
        end
        step();                                   // edge N+10
        check({tag, " busy@N+10"},  busy,      1'b0);
        check({tag, " done@N+10"},  keys_done, 1'b1);
        check({tag, " ready@N+10"}, key_ready, 1'b1);
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 16; r++) begin
            rd_round = 4'(r);
            step();
            check($sformatf("%s rd%0d", tag, r), rd_key, exp_read(r));
        end
    endtask

    task automatic read_one(input int r, output logic [127:0] val);
        rd_round = 4'(r);
        step();
        val = rd_key;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] v;
        logic [127:0] rk;

        build_sbox();

        // reset with key_valid held high: reset wins
        rst       = 1'b1;
        key_valid = 1'b1;
        aes_key   = FIPS_KEY;
        rd_round  = 4'd0;
        step(); step(); step();
        check("rst ready", key_ready, 1'b0);
        check("rst busy",  busy,      1'b0);
        check("rst done",  keys_done, 1'b0);
        check("rst rdkey", rd_key,    '0);
        rst       = 1'b0;
        key_valid = 1'b0;
        step();
        check("idle ready", key_ready, 1'b1);
        check("idle busy",  busy,      1'b0);
        rd_round = 4'd0;
        step();
        check("idle rd0 zero", rd_key, '0);

        // FIPS key, with a second key presented mid-expansion (must be ignored)
        compute_model(FIPS_KEY);
        run_expand(FIPS_KEY, SEQ_KEY, 1'b1, 1'b0, "fips");
        read_all("fips");
`ifdef AES_KEY_REVERSE_EN
        read_one(0, v);  check("fips const rd0",  v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_one(10, v); check("fips const rd10", v, FIPS_KEY);
`else
        read_one(1, v);  check("fips const rd1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_one(10, v); check("fips const rd10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
        read_one(11, v); check("rd11 zero", v, '0);
        read_one(15, v); check("rd15 zero", v, '0);

        // second key accepted from DONE
        compute_model(SEQ_KEY);
        run_expand(SEQ_KEY, '0, 1'b0, 1'b0, "seq");
        read_one(rd_for(10), v);
        check("seq const r10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read_all("seq");

        // random keys
        for (int k = 0; k < 3; k++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            compute_model(rk);
            run_expand(rk, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0,
                       $sformatf("rnd%0d", k));
            read_all($sformatf("rnd%0d", k));
        end

        // reset at edge N+5 aborts expansion and clears storage
        aes_key   = FIPS_KEY;
        key_valid = 1'b1;
        step();                 // edge N
        key_valid = 1'b0;
        step(); step(); step(); step();   // N+4
        check("abort busy@N+4", busy, 1'b1);
        rst = 1'b1;
        step();                 // N+5
        check("abort ready", key_ready, 1'b0);
        check("abort busy",  busy,      1'b0);
        check("abort done",  keys_done, 1'b0);
        check("abort rdkey", rd_key,    '0);
        rst = 1'b0;
        for (int r = 0; r < 11; r++) begin
            read_one(r, v);
            check($sformatf("cleared rd%0d", r), v, '0);
        end
        check("abort idle ready", key_ready, 1'b1);
        check("abort idle done",  keys_done, 1'b0);

        compute_model(FIPS_KEY);
        run_expand(FIPS_KEY, '0, 1'b0, 1'b1, "refips");
        read_all("refips");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port aes_key, input, 128 bits: AES-128 cipher key; bit 127 is the first key byte's MSB.
REQ-004 The block SHALL have the port key_valid, input, 1 bit: aes_key is valid this cycle.
REQ-005 The block SHALL have the port key_ready, output, 1 bit: the block accepts a key this cycle.
REQ-006 The block SHALL have the port busy, output, 1 bit: expansion is in progress.
REQ-007 The block SHALL have the port keys_done, output, 1 bit: all 11 round keys are stored and stable.
REQ-008 The block SHALL have the port rd_round, input, 4 bits: round-key read index.
REQ-009 The block SHALL have the port rd_key, output, 128 bits: registered round key selected by rd_round; feeds the inverse AES datapath.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, EXPAND and DONE.
REQ-011 key_ready SHALL be 1 in IDLE and DONE, and 0 in EXPAND and while rst is high.
REQ-012 A key SHALL be accepted on a rising edge where key_valid && key_ready; this is edge N.
REQ-013 At edge N the block SHALL store aes_key as round key 0, set the round counter to 1, set rcon to 8'h01, clear keys_done and enter EXPAND.
REQ-014 Each EXPAND cycle SHALL compute one round key from the previous one per FIPS-197.
REQ-015 The round-key computation SHALL be: RotWord, then SubWord via four forward S-box instances, then XOR with {rcon,24'h0}, then chained XOR of words w0..w3.
REQ-016 After each stored round key, rcon SHALL be updated by GF(2^8) xtime, reducing with 8'h1B on overflow (01,02,...,80,1B,36).
REQ-017 Round key r SHALL be stored at edge N+r, for r = 1..10.
REQ-018 At edge N+10 the FSM SHALL enter DONE and keys_done SHALL become 1, giving a total latency of 10 cycles after acceptance.
REQ-019 busy SHALL be 1 exactly in EXPAND.
REQ-020 key_valid during EXPAND SHALL be ignored: no restart and no corruption.
REQ-021 key_valid in DONE SHALL be accepted as in REQ-013 and SHALL clear keys_done at that edge.
REQ-022 rd_key SHALL equal the stored key at index rd_round, registered with 1-cycle read latency.
REQ-023 rd_round values 11..15 SHALL produce rd_key = 0.
REQ-024 Reads during EXPAND SHALL be permitted and SHALL return current storage contents, which are stale or partial for the remaining rounds.
REQ-025 The round counter SHALL never exceed 10 and SHALL not wrap.

Reset
REQ-026 While rst is high, the FSM SHALL be IDLE and the round counter, rcon, all 11 stored round keys, rd_key, busy and keys_done SHALL be 0.
REQ-027 rst asserted mid-EXPAND SHALL abort the expansion at that edge, and the next accepted key SHALL restart expansion from round 0.
REQ-028 rst SHALL take priority over a simultaneous key_valid.

Configuration
REQ-029 With AES_KEY_REVERSE_EN defined, the read index SHALL be mapped to 10 - rd_round for rd_round 0..10, so rd_round = 0 returns round key 10 (decryption order); indices 11..15 SHALL still return 0.
REQ-030 Without AES_KEY_REVERSE_EN, the read index SHALL equal rd_round.
REQ-031 Expansion timing and handshake SHALL be identical with and without AES_KEY_REVERSE_EN.

Verification
REQ-032 Without the macro: key 2b7e151628aed2a6abf7158809cf4f3c with key_valid=1 for one cycle -> rd_round=1 returns a0fafe1788542cb123a339392a6c7605, and rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 Timing: key accepted at edge N -> busy=1 on edges N..N+9, keys_done=1 from edge N+10, key_ready=0 during EXPAND.
REQ-034 Second key 000102030405060708090a0b0c0d0e0f presented in EXPAND -> ignored; presented in DONE -> accepted, and round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-035 rst pulsed at edge N+5 -> keys_done=0, rd_key=0 and all storage 0; re-sending the FIPS key gives correct round keys again.
REQ-036 rd_round=11 or 15 -> rd_key=0 one cycle later.
REQ-037 With AES_KEY_REVERSE_EN defined and the FIPS key: rd_round=0 returns d014f9a8c9ee2589e13f0cc8b6630ca6, and rd_round=10 returns 2b7e151628aed2a6abf7158809cf4f3c.
